// File: rtl/tt_um_jleugeri_ttt_router_if.sv
// tt_um_jleugeri_ttt_router_if: sweep handshake, connection-table write port and token-delta outputs of the router.
interface tt_um_jleugeri_ttt_router_if #(
    parameter int NUM_PROCESSORS  = 10,
    parameter int NEW_TOKENS_BITS = 4
);
    localparam int IDX_W = $clog2(NUM_PROCESSORS);
    logic                                        go;
    logic [2*NUM_PROCESSORS-1:0]                 tstartstop;
    logic                                        cfg_we;
    logic [IDX_W-1:0]                            cfg_addr;
    logic                                        cfg_valid;
    logic [IDX_W-1:0]                            cfg_first;
    logic [IDX_W-1:0]                            cfg_last;
    logic [NEW_TOKENS_BITS-1:0]                  cfg_good_w;
    logic [NEW_TOKENS_BITS-1:0]                  cfg_bad_w;
    logic                                        hot;
    logic                                        done;
    logic                                        enable;
    logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0]   new_good_tokens;
    logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0]   new_bad_tokens;
    modport master (
        output go, tstartstop, cfg_we, cfg_addr, cfg_valid, cfg_first, cfg_last, cfg_good_w, cfg_bad_w,
        input  hot, done, enable, new_good_tokens, new_bad_tokens
    );
    modport slave (
        input  go, tstartstop, cfg_we, cfg_addr, cfg_valid, cfg_first, cfg_last, cfg_good_w, cfg_bad_w,
        output hot, done, enable, new_good_tokens, new_bad_tokens
    );
endinterface

// File: rtl/tt_um_jleugeri_ttt_router.sv
// tt_um_jleugeri_ttt_router: sweeps start/stop flags, fans each active source out over its target range.
// Define TTT_ROUTER_SATURATE_EN to clamp accumulators; otherwise they wrap.
module tt_um_jleugeri_ttt_router #(
    parameter int NUM_PROCESSORS  = 10,
    parameter int NEW_TOKENS_BITS = 4
) (
    input logic clk,
    input logic rst_n,
    tt_um_jleugeri_ttt_router_if.slave bus
);
    localparam int N     = NUM_PROCESSORS;
    localparam int B     = NEW_TOKENS_BITS;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [B+1:0] SMAX = (B+2)'(2 ** (B - 1) - 1);
    localparam logic signed [B+1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, SCAN, FANOUT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        src_q, src_d, tgt_q, tgt_d;
    logic                    hot_q, done_q, en_q;
    logic [N-1:0]            start_q, stop_q, valid_q;
    logic [IDX_W-1:0]        first_q [N];
    logic [IDX_W-1:0]        last_q [N];
    logic signed [B-1:0]     good_w_q [N];
    logic signed [B-1:0]     bad_w_q [N];
    logic signed [B-1:0]     good_q [N];
    logic signed [B-1:0]     bad_q [N];
    logic                    start, act, at_end;
    logic [IDX_W-1:0]        last_eff;

    // Wide domain keeps negation of the most negative weight exact before reduction.
    function automatic logic signed [B-1:0] accum(input logic signed [B-1:0] acc,
                                                  input logic signed [B-1:0] w, input logic neg);
        logic signed [B+1:0] s;
        s = neg ? (B+2)'(acc) - (B+2)'(w) : (B+2)'(acc) + (B+2)'(w);
`ifdef TTT_ROUTER_SATURATE_EN
        return s > SMAX ? SMAX[B-1:0] : s < SMIN ? SMIN[B-1:0] : s[B-1:0];
`else
        return s[B-1:0];
`endif
    endfunction

    assign start    = state_q == IDLE && bus.go;
    assign last_eff = last_q[src_q] > LAST_IDX ? LAST_IDX : last_q[src_q];
    assign act      = (start_q[src_q] ^ stop_q[src_q]) && valid_q[src_q]
                      && first_q[src_q] <= last_q[src_q] && first_q[src_q] <= LAST_IDX;
    assign at_end   = tgt_q == last_eff;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            IDLE: begin
                state_d = bus.go ? SCAN : IDLE;
                src_d   = bus.go ? '0 : src_q;
            end
            SCAN: begin
                state_d = act ? FANOUT : src_q == LAST_IDX ? DONE : SCAN;
                src_d   = act || src_q == LAST_IDX ? src_q : src_q + 1'b1;
                tgt_d   = act ? first_q[src_q] : tgt_q;
            end
            FANOUT: begin
                state_d = !at_end ? FANOUT : src_q == LAST_IDX ? DONE : SCAN;
                src_d   = at_end && src_q != LAST_IDX ? src_q + 1'b1 : src_q;
                tgt_d   = at_end ? tgt_q : tgt_q + 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            tgt_q   <= '0;
            hot_q   <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < N; i++) begin
                first_q[i]  <= '0;
                last_q[i]   <= '0;
                good_w_q[i] <= '0;
                bad_w_q[i]  <= '0;
                good_q[i]   <= '0;
                bad_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            tgt_q   <= tgt_d;
            hot_q   <= state_d == SCAN || state_d == FANOUT;
            done_q  <= state_d == DONE;
            en_q    <= state_d == DONE || (en_q && !start);
            if (state_q == IDLE && bus.cfg_we && bus.cfg_addr <= LAST_IDX) begin
                valid_q[bus.cfg_addr]  <= bus.cfg_valid;
                first_q[bus.cfg_addr]  <= bus.cfg_first;
                last_q[bus.cfg_addr]   <= bus.cfg_last;
                good_w_q[bus.cfg_addr] <= bus.cfg_good_w;
                bad_w_q[bus.cfg_addr]  <= bus.cfg_bad_w;
            end
            if (start) begin
                for (int i = 0; i < N; i++) begin
                    start_q[i] <= bus.tstartstop[2*i];
                    stop_q[i]  <= bus.tstartstop[2*i+1];
                    good_q[i]  <= '0;
                    bad_q[i]   <= '0;
                end
            end
            if (state_q == FANOUT) begin
                good_q[tgt_q] <= accum(good_q[tgt_q], good_w_q[src_q], stop_q[src_q]);
                bad_q[tgt_q]  <= accum(bad_q[tgt_q], bad_w_q[src_q], stop_q[src_q]);
            end
        end
    end

    assign bus.hot    = hot_q;
    assign bus.done   = done_q;
    assign bus.enable = en_q;

    for (genvar g = 0; g < N; g++) begin : g_out
        assign bus.new_good_tokens[g*B +: B] = good_q[g];
        assign bus.new_bad_tokens[g*B +: B]  = bad_q[g];
    end
endmodule
